// File: rtl/muldiv_unit_if.sv
// Handshake and operand/result bundle between the multicycle controller
// and the iterative multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srca, srcb,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srca, srcb,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit (MULTU/MULT/DIVU/DIV) with HI/LO
// results. One shared 32-bit ripple adder does all partial-product and
// partial-remainder arithmetic; latency is a fixed 35 cycles.

// Plain 32-bit ripple adder with no carry-out.
module add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a + b;
endmodule

module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t           state, state_nx;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r;     // operands as captured
    logic [WIDTH-1:0] m_r;          // multiplicand, or negated divisor
    logic [WIDTH-1:0] acc_r;        // product high half, or remainder
    logic [WIDTH-1:0] lq_r;         // multiplier/product low half, or quotient
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             sgn_res, sgn_rem;
    logic [4:0]       cnt;

    logic             busy_c, done_c;
    logic             is_div, is_sgn;
    logic [WIDTH-1:0] ua, ub, srem;
    logic [31:0]      add_a, add_b, add_y;
    logic             carry;
    logic [WIDTH:0]   acc33;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        return (v < 0) ? 32'(-v) : 32'(v);
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    assign is_div = op_r[1];
    assign is_sgn = op_r[0];
    assign ua     = is_sgn ? abs32(a_r) : a_r;
    assign ub     = is_sgn ? abs32(b_r) : b_r;
    // Remainder after the left shift; its bit 32 is acc_r[31].
    assign srem   = {acc_r[30:0], lq_r[31]};

    add u_add (.a(add_a), .b(add_b), .y(add_y));

    // Adder operand select and synthesized carry-out / multiply accumulate
    always_comb begin
        add_a = acc_r;
        add_b = m_r;
        if (state == PREP) begin
            add_a = ~ub;
            add_b = 32'd1;
        end else if (is_div) begin
            add_a = srem;
        end
        carry = (add_a[31] & add_b[31]) | ((add_a[31] ^ add_b[31]) & ~add_y[31]);
        acc33 = lq_r[0] ? {carry, add_y} : {1'b0, acc_r};
    end

    // Sign/special-case correction of the raw result for HI/LO
    always_comb begin
        fix_hi = acc_r;
        fix_lo = lq_r;
        if (!is_div) begin
            if (sgn_res)
                {fix_hi, fix_lo} = neg64({acc_r, lq_r});
        end else if (b_r == '0) begin
            fix_hi = a_r;
            fix_lo = '1;
        end else begin
            fix_lo = sgn_res ? neg32(lq_r) : lq_r;
            fix_hi = sgn_rem ? neg32(acc_r) : acc_r;
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        state_nx = state;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nx = PREP;
            PREP: begin
                busy_c   = 1'b1;
                state_nx = ITER;
            end
            ITER: begin
                busy_c = 1'b1;
                if (cnt == 5'(ITERS - 1)) state_nx = FIX;
            end
            FIX: begin
                busy_c   = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Iteration counter and architecturally visible HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            hi_r <= '0;
            lo_r <= '0;
        end else begin
            if (state == PREP)      cnt <= '0;
            else if (state == ITER) cnt <= cnt + 5'd1;
            if (state == FIX) begin
                hi_r <= fix_hi;
                lo_r <= fix_lo;
            end
        end
    end

    // Operand capture, preparation and shift-add / restoring-divide steps
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (bus.start) begin
                op_r <= bus.op;
                a_r  <= bus.srca;
                b_r  <= bus.srcb;
            end
            PREP: begin
                sgn_res <= is_sgn & (a_r[31] ^ b_r[31]);
                sgn_rem <= is_sgn & a_r[31];
                acc_r   <= '0;
                if (is_div) begin
                    m_r  <= add_y;
                    lq_r <= ua;
                end else begin
                    m_r  <= ua;
                    lq_r <= ub;
                end
            end
            ITER: begin
                if (is_div) begin
                    if (acc_r[31] | carry) begin
                        acc_r <= add_y;
                        lq_r  <= {lq_r[30:0], 1'b1};
                    end else begin
                        acc_r <= srem;
                        lq_r  <= {lq_r[30:0], 1'b0};
                    end
                end else begin
                    acc_r <= acc33[WIDTH:1];
                    lq_r  <= {acc33[0], lq_r[WIDTH-1:1]};
                end
            end
            default: ;
        endcase
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, handshake, signed and
// unsigned results, divide-by-zero, overflow, ignored start and reset abort.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;
    int   nchk  = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32), .ITERS(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation and check latency, handshake and HI/LO.
    // inj != 0 pulses a second start after that many edges of the operation.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int inj);
        int n;
        int extra;
        bit busy_bad;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, ".busy_start"}, 64'(bus.busy), 64'd1);
        n = 0;
        busy_bad = 1'b0;
        while (!bus.done && n < 60) begin
            if (!bus.busy) busy_bad = 1'b1;
            @(posedge clk); #1;
            n++;
            if (inj != 0 && n == inj) begin
                bus.start = 1'b1;
                bus.op    = 2'b10;
                bus.srca  = 32'd9;
                bus.srcb  = 32'd2;
            end
            if (inj != 0 && n == inj + 1) bus.start = 1'b0;
        end
        check({tag, ".latency"}, 64'(n), 64'd34);
        check({tag, ".busy_held"}, 64'(busy_bad), 64'd0);
        check({tag, ".busy_in_done"}, 64'(bus.busy), 64'd0);
        check({tag, ".hi"}, 64'(bus.hi), 64'(ehi));
        check({tag, ".lo"}, 64'(bus.lo), 64'(elo));
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
        if (inj != 0) begin
            extra = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (bus.done || bus.busy) extra++;
            end
            check({tag, ".no_second_op"}, 64'(extra), 64'd0);
            check({tag, ".hi_hold"}, 64'(bus.hi), 64'(ehi));
            check({tag, ".lo_hold"}, 64'(bus.lo), 64'(elo));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.srca  = '0;
        bus.srcb  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.done", 64'(bus.done), 64'd0);
        check("rst.hi",   64'(bus.hi),   64'd0);
        check("rst.lo",   64'(bus.lo),   64'd0);

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("mult_zero", 2'b01, 32'd0,         32'hFFFF_FFF9, 32'd0,         32'd0,         0);
        run_op("divu",      2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        0);
        run_op("div_neg",   2'b11, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 0);
        run_op("div_negb",  2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0);
        run_op("divu_zero", 2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 0);
        run_op("div_zero",  2'b11, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF, 0);
        run_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0);
        run_op("multu_inj", 2'b00, 32'h1234_5678, 32'h10,        32'd1,         32'h2345_6780, 10);

        // Abort a DIV at cycle 20 with reset
        bus.op    = 2'b11;
        bus.srca  = 32'd1000;
        bus.srcb  = 32'd3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort.busy", 64'(bus.busy), 64'd0);
        check("abort.done", 64'(bus.done), 64'd0);
        check("abort.hi",   64'(bus.hi),   64'd0);
        check("abort.lo",   64'(bus.lo),   64'd0);

        run_op("after_rst", 2'b01, 32'd6, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFE8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative 32-bit multiply/divide unit for the multicycle MIPS datapath. It sits beside the ALU and drives an internal instance of the ripple `add` block with partial products or partial remainders every cycle. It returns 64-bit results in HI/LO for MULT/MULTU/DIV/DIVU, with a start/busy/done handshake toward the multicycle controller.

Parameters:
WIDTH, 32, operand width. Only 32 is supported; `add` is fixed at 32 bits.
ITERS, 32, iteration count. Must equal WIDTH.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; captured with start
srca  in  32  multiplicand / dividend; captured with start
srcb  in  32  multiplier / divisor; captured with start
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse when hi/lo become valid
hi  out  32  product[63:32] / remainder
lo  out  32  product[31:0] / quotient

Behaviour:
- Reset (sync, active-high, takes priority over everything): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. Reset asserted mid-operation aborts the operation; no done pulse is produced.
- State machine: IDLE -> PREP -> ITER (ITERS cycles) -> FIX -> DONE -> IDLE.
- IDLE: busy=0. If start=1, capture op, srca and srcb, and go to PREP.
- PREP (1 cycle):
  - Signed ops: take the absolute values of the operands and record the result sign (srca[31]^srcb[31]) and the remainder sign (srca[31]).
  - Divide: form the negated divisor ~|b|+1 via `add`.
- ITER (32 cycles, counter 0..31):
  - Multiply: shift-add on a 64-bit {acc, mplier} register. If mplier[0]=1, acc = acc + mcand through `add`, with the carry-out captured by a separate 33rd bit. Then shift right by 1.
  - Divide: restoring algorithm. Shift {rem, quot} left by 1 and compute trial = rem + (−divisor) through `add`. If the trial is non-negative (unsigned compare, 33-bit), set rem = trial and quot[0]=1.
- FIX (1 cycle):
  - MULT: if the result sign=1, two's-complement negate the 64-bit product.
  - DIV: negate the quotient if the result sign=1; negate the remainder if the dividend was negative.
  - Load hi/lo.
- DONE (1 cycle): done=1, busy=0, then return to IDLE.
- Latency: the start-sampling edge is edge 0. busy=1 from edge 0 through edge 34. hi/lo are updated at edge 34. done=1 for exactly the cycle between edges 34 and 35. Total latency is 35 cycles, fixed for all ops and data values.
- hi/lo hold their value until the next operation's FIX. They are never visible in a partial state.
- start while busy=1: ignored; no queuing.
- start in the DONE cycle: ignored. It is accepted on the next cycle in IDLE.
- Divide by zero, DIVU and DIV: lo=32'hFFFF_FFFF, hi=srca (unmodified dividend). Busy and latency are unchanged.
- DIV overflow, 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- Signed division truncates toward zero. The remainder has the sign of the dividend.
- Carry-out: `add` exposes no carry. The 33rd bit is derived as (a[31]&b[31]) | ((a[31]^b[31]) & ~sum[31]).

Test Plan:
- MULTU 32'hFFFF_FFFF × 32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001; done exactly 35 cycles after start.
- MULT −3 (32'hFFFF_FFFD) × 7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB; MULT 0×x -> hi=lo=0.
- DIVU 100 / 7 -> lo=14, hi=2. DIV −100 / 7 -> lo=32'hFFFF_FFF2 (−14), hi=32'hFFFF_FFFE (−2).
- DIVU 5 / 0 -> lo=32'hFFFF_FFFF, hi=5. DIV 32'h8000_0000 / −1 -> lo=32'h8000_0000, hi=0.
- Second start pulse at cycle 10 of a busy MULTU -> ignored: hi/lo hold the first result, a single done pulse occurs, and busy is unaffected.
- Reset asserted at cycle 20 of a DIV -> next cycle busy=0, done=0, hi=lo=0. A new start is then accepted and completes normally 35 cycles later.
